// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline event tracer: record flag bit positions,
// record field widths, drop counter width and a record-width helper.
package pipe_trace_pkg;

  // Bit positions inside the 6-bit flags field.
  localparam int FLG_STALL      = 0;
  localparam int FLG_BRANCH     = 1;
  localparam int FLG_FWD_A      = 2;
  localparam int FLG_FWD_B      = 3;
  localparam int FLG_FLUSH_IFID = 4;
  localparam int FLG_FLUSH_IDEX = 5;

  // Record field widths (cycle stamp width is a parameter of the top).
  localparam int FLAGS_W = 6;
  localparam int FWD_W   = 4;
  localparam int PC_W    = 32;
  localparam int AUX_W   = 32;

  // Dropped-record counter width.
  localparam int DROP_W  = 16;

  // Total record width: {cycle, flags, fwd, pc, aux}.
  function automatic int rec_width(input int cycle_w);
    return cycle_w + FLAGS_W + FWD_W + PC_W + AUX_W;
  endfunction

endpackage

// File: rtl/pipe_event_tracer_if.sv
// Read-side bundle of the pipeline event tracer.
//   master : tracer side, drives head record, status and counters; samples rd_ready
//   slave  : consumer side, drives rd_ready; samples everything else
interface pipe_event_tracer_if #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32
);
  import pipe_trace_pkg::*;

  logic                     rd_valid;
  logic                     rd_ready;
  logic [CYCLE_W-1:0]       rd_cycle;
  logic [FLAGS_W-1:0]       rd_flags;
  logic [FWD_W-1:0]         rd_fwd;
  logic [PC_W-1:0]          rd_pc;
  logic [AUX_W-1:0]         rd_aux;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_cnt;

  modport master (
    output rd_valid, rd_cycle, rd_flags, rd_fwd, rd_pc, rd_aux,
           count, overflow, drop_cnt,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_cycle, rd_flags, rd_fwd, rd_pc, rd_aux,
           count, overflow, drop_cnt,
    output rd_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   i_clk/i_rst : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_data, o_full : write side; a push while full is accepted only
//                           together with a pop on the same edge
//   i_pop, o_empty/o_data : read side; o_data is the head entry
//   o_count               : entries held
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  output logic                   o_full,
  input  logic                   i_pop,
  output logic                   o_empty,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_event_tracer.sv
// Pipeline hazard event recorder. Every cycle with a stall, taken branch,
// forwarding or flush (and en=1) is packed into a timestamped record and
// queued in a FWFT FIFO; when the FIFO is full the newest record is dropped.
//   clk, rstn        : clock, synchronous active-high reset
//   en               : capture enable
//   pc, inst, stall, branch_taken, branch_target, forward_a/b, flush_ifid/idex
//                    : sampled pipeline status
//   rd (master)      : head record, valid/ready handshake, count, overflow, drop_cnt
module pipe_event_tracer
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [31:0]  pc,
  input  logic [31:0]  inst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic [1:0]   forward_a,
  input  logic [1:0]   forward_b,
  input  logic         flush_ifid,
  input  logic         flush_idex,
  pipe_event_tracer_if.master rd
);

  localparam int REC_W   = rec_width(CYCLE_W);
  localparam int AUX_LO  = 0;
  localparam int PC_LO   = AUX_LO + AUX_W;
  localparam int FWD_LO  = PC_LO + PC_W;
  localparam int FLG_LO  = FWD_LO + FWD_W;
  localparam int CYC_LO  = FLG_LO + FLAGS_W;

  logic [CYCLE_W-1:0]     r_cycle;
  logic                   r_overflow;
  logic [DROP_W-1:0]      r_drop_cnt;

  logic [FLAGS_W-1:0]     w_flags;
  logic [AUX_W-1:0]       w_aux;
  logic [REC_W-1:0]       w_rec;
  logic [REC_W-1:0]       w_head_raw;
  logic [REC_W-1:0]       w_head;
  logic                   w_req;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic [$clog2(DEPTH):0] w_count;

  always_ff @(posedge clk) begin
    if (rstn) r_cycle <= '0;
    else      r_cycle <= r_cycle + 1'b1;
  end

  always_comb begin
    w_flags                 = '0;
    w_flags[FLG_STALL]      = stall;
    w_flags[FLG_BRANCH]     = branch_taken;
    w_flags[FLG_FWD_A]      = (forward_a != 2'b00);
    w_flags[FLG_FWD_B]      = (forward_b != 2'b00);
    w_flags[FLG_FLUSH_IFID] = flush_ifid;
    w_flags[FLG_FLUSH_IDEX] = flush_idex;
  end

  assign w_aux = branch_taken ? branch_target : inst;
  assign w_rec = {r_cycle, w_flags, forward_a, forward_b, pc, w_aux};
  assign w_req = en & (|w_flags);

  assign w_pop  = rd.rd_valid & rd.rd_ready;
  // Full without a same-edge pop means the new record has nowhere to go.
  assign w_drop = w_req & w_full & ~w_pop;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rstn),
    .i_push  (w_req),
    .i_data  (w_rec),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_data  (w_head_raw),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Storage is not cleared on reset, so the head is masked while empty.
  assign w_head = w_empty ? '0 : w_head_raw;

  assign rd.rd_valid = ~w_empty;
  assign rd.rd_cycle = w_head[CYC_LO +: CYCLE_W];
  assign rd.rd_flags = w_head[FLG_LO +: FLAGS_W];
  assign rd.rd_fwd   = w_head[FWD_LO +: FWD_W];
  assign rd.rd_pc    = w_head[PC_LO +: PC_W];
  assign rd.rd_aux   = w_head[AUX_LO +: AUX_W];
  assign rd.count    = w_count;
  assign rd.overflow = r_overflow;
  assign rd.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pipe_event_tracer.sv
module tb_pipe_event_tracer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        flush_ifid;
  logic        flush_idex;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_event_tracer_if #(.DEPTH(16), .CYCLE_W(32)) rd_if ();

  pipe_event_tracer #(
    .DEPTH   (16),
    .CYCLE_W (32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .pc            (pc),
    .inst          (inst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .rd            (rd_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs set before step() are sampled at its edge; outputs are checked 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_target = '0;
    forward_a = 0; forward_b = 0; flush_ifid = 0; flush_idex = 0;
  endtask

  task automatic do_reset();
    rstn = 1;
    step();
    rstn = 0;
  endtask

  initial begin
    rstn = 1; en = 1; pc = '0; inst = '0;
    rd_if.rd_ready = 0;
    idle_inputs();
    step(); step();

    // Reset state
    check("rst_valid", 64'(rd_if.rd_valid), 64'd0);
    check("rst_count", 64'(rd_if.count), 64'd0);
    check("rst_ovf",   64'(rd_if.overflow), 64'd0);
    check("rst_drop",  64'(rd_if.drop_cnt), 64'd0);
    check("rst_cycle", 64'(rd_if.rd_cycle), 64'd0);
    rstn = 0;

    // Single stall event on cycle 3, held while rd_ready=0
    step(); step(); step();
    check("pre_valid", 64'(rd_if.rd_valid), 64'd0);
    stall = 1; pc = 32'h0000_0100; inst = 32'hDEAD_BEEF;
    step();
    idle_inputs(); pc = 32'h0000_0200; inst = 32'h1111_2222;
    check("s_valid", 64'(rd_if.rd_valid), 64'd1);
    check("s_cycle", 64'(rd_if.rd_cycle), 64'd3);
    check("s_flags", 64'(rd_if.rd_flags), 64'h01);
    check("s_aux",   64'(rd_if.rd_aux), 64'hDEAD_BEEF);
    check("s_pc",    64'(rd_if.rd_pc), 64'h100);
    check("s_count", 64'(rd_if.count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("s_hold_cycle", 64'(rd_if.rd_cycle), 64'd3);
      check("s_hold_aux",   64'(rd_if.rd_aux), 64'hDEAD_BEEF);
    end

    // rd_ready while empty after reset has no effect
    do_reset();
    rd_if.rd_ready = 1;
    step();
    check("empty_rdy_count", 64'(rd_if.count), 64'd0);
    check("empty_rdy_valid", 64'(rd_if.rd_valid), 64'd0);
    rd_if.rd_ready = 0;

    // Branch record on cycle 7
    do_reset();
    for (int i = 0; i < 7; i++) step();
    branch_taken = 1; branch_target = 32'h0000_0040; forward_a = 2'b10;
    inst = 32'h0000_1234; pc = 32'h0000_0300;
    step();
    idle_inputs();
    check("b_cycle", 64'(rd_if.rd_cycle), 64'd7);
    check("b_flags", 64'(rd_if.rd_flags), 64'h06);
    check("b_fwd",   64'(rd_if.rd_fwd), 64'h8);
    check("b_aux",   64'(rd_if.rd_aux), 64'h40);

    // Fill and overflow: 20 events (cycles 0..19), 16 kept, 4 dropped
    do_reset();
    stall = 1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'h1000 + 32'(i);
      step();
    end
    idle_inputs();
    check("f_count", 64'(rd_if.count), 64'd16);
    check("f_ovf",   64'(rd_if.overflow), 64'd1);
    check("f_drop",  64'(rd_if.drop_cnt), 64'd4);
    check("f_head",  64'(rd_if.rd_cycle), 64'd0);

    // Full with simultaneous read and write on cycle 20
    stall = 1; pc = 32'h0000_0ABC; rd_if.rd_ready = 1;
    step();
    idle_inputs(); rd_if.rd_ready = 0;
    check("rw_count", 64'(rd_if.count), 64'd16);
    check("rw_drop",  64'(rd_if.drop_cnt), 64'd4);
    check("rw_head",  64'(rd_if.rd_cycle), 64'd1);

    // Drain: cycles 1..15 then the cycle-20 record at the tail
    rd_if.rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("d_valid", 64'(rd_if.rd_valid), 64'd1);
      check("d_cycle", 64'(rd_if.rd_cycle), (i < 15) ? 64'(i + 1) : 64'd20);
      if (i == 15) check("d_tail_pc", 64'(rd_if.rd_pc), 64'hABC);
      step();
    end
    rd_if.rd_ready = 0;
    check("d_empty", 64'(rd_if.rd_valid), 64'd0);
    check("d_count", 64'(rd_if.count), 64'd0);
    check("d_ovf_sticky", 64'(rd_if.overflow), 64'd1);

    // Gating and idle cycles keep the counter running
    do_reset();
    en = 0; stall = 1;
    for (int i = 0; i < 10; i++) step();
    check("g_count", 64'(rd_if.count), 64'd0);
    en = 1; stall = 0;
    for (int i = 0; i < 5; i++) step();
    check("idle_count", 64'(rd_if.count), 64'd0);
    flush_idex = 1; flush_ifid = 1; forward_b = 2'b01; inst = 32'hCAFE_0000;
    step();
    idle_inputs();
    check("g_cycle", 64'(rd_if.rd_cycle), 64'd15);
    check("g_flags", 64'(rd_if.rd_flags), 64'h38);
    check("g_fwd",   64'(rd_if.rd_fwd), 64'h1);
    check("g_aux",   64'(rd_if.rd_aux), 64'hCAFE_0000);

    // Reset mid-run with records buffered and overflow set
    stall = 1;
    for (int i = 0; i < 20; i++) step();
    idle_inputs();
    check("m_ovf_pre", 64'(rd_if.overflow), 64'd1);
    rstn = 1;
    step();
    check("m_valid", 64'(rd_if.rd_valid), 64'd0);
    check("m_count", 64'(rd_if.count), 64'd0);
    check("m_ovf",   64'(rd_if.overflow), 64'd0);
    check("m_drop",  64'(rd_if.drop_cnt), 64'd0);
    rstn = 0; stall = 1;
    step();
    idle_inputs();
    check("m_cycle0", 64'(rd_if.rd_cycle), 64'd0);
    check("m_valid1", 64'(rd_if.rd_valid), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
